// File: rtl/led_panel_cmd_ctrl.sv
// Byte-stream command decoder driving the back bank of a double-buffered 16x8 LED
// frame buffer, plus the colour register and front/back bank selection.
module led_panel_cmd_ctrl #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [2:0] RGB_RESET      = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       frame_boundary,
  output logic       fb_we,
  output logic [3:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       front_sel,
  output logic [2:0] rgb,
  output logic       busy,
  output logic       err_overrun,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, COL_DATA, CLEAR, FRAME_DATA, SWAP_WAIT} state_t;

  state_t        state, state_n;
  logic [3:0]    col, col_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          we_n, front_n, ovr_n, err_inc;
  logic [3:0]    addr_n;
  logic [7:0]    data_n;
  logic [2:0]    rgb_n;
  logic          tmo_hit;

  assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    col_n   = col;
    tmo_n   = tmo;
    we_n    = 1'b0;
    addr_n  = fb_addr;
    data_n  = fb_data;
    front_n = front_sel;
    rgb_n   = rgb;
    ovr_n   = err_overrun;
    err_inc = 1'b0;
    case (state)
      IDLE: begin
        tmo_n = '0;
        if (rx_dv) begin
          if (rx_byte[7:4] == 4'h1) begin
            col_n   = rx_byte[3:0];
            state_n = COL_DATA;
          end else if (rx_byte[7:3] == 5'b00100) begin
            rgb_n = rx_byte[2:0];
          end else if (rx_byte == 8'h30) begin
            // Column 0 is issued with the opcode so the clear starts the next cycle.
            we_n    = 1'b1;
            addr_n  = 4'd0;
            data_n  = 8'h00;
            col_n   = 4'd1;
            state_n = CLEAR;
          end else if (rx_byte == 8'h40) begin
            col_n   = 4'd0;
            state_n = FRAME_DATA;
          end else if (rx_byte == 8'h50) begin
            state_n = SWAP_WAIT;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      COL_DATA: begin
        if (rx_dv) begin
          we_n    = 1'b1;
          addr_n  = col;
          data_n  = rx_byte;
          state_n = IDLE;
        end else if (tmo_hit) begin
          err_inc = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      FRAME_DATA: begin
        if (rx_dv) begin
          we_n   = 1'b1;
          addr_n = col;
          data_n = rx_byte;
          col_n  = col + 4'd1;
          tmo_n  = '0;
          if (col == 4'd15) state_n = IDLE;
        end else if (tmo_hit) begin
          err_inc = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      CLEAR: begin
        we_n   = 1'b1;
        addr_n = col;
        data_n = 8'h00;
        col_n  = col + 4'd1;
        if (col == 4'd15) state_n = IDLE;
        if (rx_dv) begin
          ovr_n   = 1'b1;
          err_inc = 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (frame_boundary) begin
          front_n = ~front_sel;
          state_n = IDLE;
        end
        if (rx_dv) begin
          ovr_n   = 1'b1;
          err_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      tmo         <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      front_sel   <= 1'b0;
      rgb         <= RGB_RESET;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      tmo         <= tmo_n;
      fb_we       <= we_n;
      fb_addr     <= addr_n;
      fb_data     <= data_n;
      front_sel   <= front_n;
      rgb         <= rgb_n;
      busy        <= (state_n != IDLE);
      err_overrun <= ovr_n;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_panel_cmd_ctrl.sv
// Self-checking bench for led_panel_cmd_ctrl: directed scenarios plus a randomized
// command stream checked against a command-level model of the frame-buffer writes.
module tb_led_panel_cmd_ctrl;

  localparam int TO = 25;

  logic       clk = 1'b0;
  logic       reset, rx_dv, frame_boundary;
  logic [7:0] rx_byte;
  logic       fb_we, front_sel, busy, err_overrun;
  logic [3:0] fb_addr;
  logic [7:0] fb_data, err_count;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] obs_addr[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  led_panel_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .RGB_RESET(3'b101)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .frame_boundary(frame_boundary), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .front_sel(front_sel), .rgb(rgb), .busy(busy),
    .err_overrun(err_overrun), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every frame-buffer write is logged with the edge that produced it.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      obs_addr.push_back(fb_addr);
      obs_data.push_back(fb_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic pulse_boundary();
    frame_boundary = 1'b1;
    @(negedge clk);
    frame_boundary = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    frame_boundary = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit is_valid_opcode(input logic [7:0] b);
    return (b[7:4] == 4'h1) || (b[7:3] == 5'b00100) || b == 8'h30 || b == 8'h40 || b == 8'h50;
  endfunction

  task automatic test_reset();
    do_reset();
    clear_obs();
    idle(20);
    checks++; if (rgb !== 3'b101) begin errors++; $display("[TB] FAIL reset_rgb got %b expected 101", rgb); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_front got %b expected 0", front_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_errcnt got %0d expected 0", err_count); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr got %b expected 0", err_overrun); end
    checks++; if ({fb_addr, fb_data} !== 12'h000) begin errors++; $display("[TB] FAIL reset_addr_data got %h expected 000", {fb_addr, fb_data}); end
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("[TB] FAIL reset_no_write got %0d writes expected 0", obs_addr.size()); end
  endtask

  task automatic test_set_col();
    clear_obs();
    send_byte(8'h13);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL setcol_busy got %b expected 1", busy); end
    idle(3);
    send_byte(8'hA5);
    checks++; if (fb_we !== 1'b1) begin errors++; $display("[TB] FAIL setcol_we got %b expected 1", fb_we); end
    checks++; if (fb_addr !== 4'd3) begin errors++; $display("[TB] FAIL setcol_addr got %0d expected 3", fb_addr); end
    checks++; if (fb_data !== 8'hA5) begin errors++; $display("[TB] FAIL setcol_data got %h expected a5", fb_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL setcol_busy_drop got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("[TB] FAIL setcol_we_one_cycle got %b expected 0", fb_we); end
    idle(2);
  endtask

  task automatic test_frame();
    int s;
    clear_obs();
    send_byte(8'h40);
    for (int k = 0; k < 16; k++) begin
      idle(19);
      send_byte(8'(k));
    end
    idle(3);
    send_byte(8'h30);
    s = cyc;
    idle(20);
    checks++; if (obs_addr.size() !== 32) begin errors++; $display("[TB] FAIL frame_write_count got %0d expected 32", obs_addr.size()); end
    if (obs_addr.size() == 32) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if ({obs_addr[i], obs_data[i]} !== {4'(i), 8'(i)}) begin errors++; $display("[TB] FAIL frame_write%0d got %h expected %h", i, {obs_addr[i], obs_data[i]}, {4'(i), 8'(i)}); end
        checks++; if ({obs_addr[16+i], obs_data[16+i]} !== {4'(i), 8'h00} || obs_cyc[16+i] != s + i) begin errors++; $display("[TB] FAIL frame_then_clear%0d got %h@%0d expected %h@%0d", i, {obs_addr[16+i], obs_data[16+i]}, obs_cyc[16+i], {4'(i), 8'h00}, s + i); end
      end
    end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL frame_errcnt got %0d expected 0", err_count); end
  endtask

  task automatic test_clear_drop();
    int s;
    do_reset();
    clear_obs();
    send_byte(8'h30);
    s = cyc;
    idle(4);
    send_byte(8'hFF);
    idle(14);
    checks++; if (obs_addr.size() !== 16) begin errors++; $display("[TB] FAIL clear_write_count got %0d expected 16", obs_addr.size()); end
    if (obs_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if ({obs_addr[i], obs_data[i]} !== {4'(i), 8'h00} || obs_cyc[i] != s + i) begin errors++; $display("[TB] FAIL clear_write%0d got %h@%0d expected %h@%0d", i, {obs_addr[i], obs_data[i]}, obs_cyc[i], {4'(i), 8'h00}, s + i); end
      end
    end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("[TB] FAIL clear_overrun got %b expected 1", err_overrun); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL clear_errcnt got %0d expected 1", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy got %b expected 0", busy); end
  endtask

  task automatic test_swap();
    do_reset();
    rx_dv = 1'b1;
    rx_byte = 8'h50;
    frame_boundary = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
    frame_boundary = 1'b0;
    for (int i = 0; i < 50; i++) begin
      checks++; if ({busy, front_sel} !== 2'b10) begin errors++; $display("[TB] FAIL swap_wait%0d got busy,front %b expected 10", i, {busy, front_sel}); end
      @(negedge clk);
    end
    pulse_boundary();
    checks++; if ({busy, front_sel} !== 2'b01) begin errors++; $display("[TB] FAIL swap_toggle got busy,front %b expected 01", {busy, front_sel}); end
    send_byte(8'h50);
    idle(7);
    pulse_boundary();
    checks++; if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL swap_back got %b expected 0", front_sel); end
    pulse_boundary();
    idle(1);
    checks++; if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL swap_idle_boundary got %b expected 0", front_sel); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    send_byte(8'h50);
    idle(3);
    do_reset();
    pulse_boundary();
    idle(1);
    checks++; if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL abort_swap got %b expected 0", front_sel); end
    send_byte(8'h40);
    send_byte(8'h11);
    do_reset();
    idle(2);
    clear_obs();
    send_byte(8'h07);
    idle(3);
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("[TB] FAIL abort_frame_writes got %0d expected 0", obs_addr.size()); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL abort_opcode_err got %0d expected 1", err_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    clear_obs();
    send_byte(8'h40);
    idle(2);
    send_byte(8'hAA);
    idle(2);
    send_byte(8'h55);
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_busy%0d got %b expected 1", k, busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_abort got %b expected 0", busy); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL timeout_errcnt got %0d expected 1", err_count); end
    checks++; if (obs_addr.size() !== 2) begin errors++; $display("[TB] FAIL timeout_writes got %0d expected 2", obs_addr.size()); end
    if (obs_addr.size() == 2) begin
      checks++; if ({obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]} !== 24'h0AA155) begin errors++; $display("[TB] FAIL timeout_write_vals got %h expected 0aa155", {obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]}); end
    end
    send_byte(8'h99);
    idle(1);
    checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL bad_opcode got %0d expected 2", err_count); end
    for (int i = 0; i < 300; i++) send_byte(8'h99);
    idle(2);
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL err_saturate got %0d expected 255", err_count); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL timeout_ovr got %b expected 0", err_overrun); end
  endtask

  // Command-level model: each command contributes its expected writes and register effects.
  task automatic test_random();
    logic [3:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [2:0] exp_rgb;
    logic       exp_front;
    int         exp_err;
    logic [7:0] b;
    logic [3:0] c;
    do_reset();
    clear_obs();
    exp_rgb = 3'b101;
    exp_front = 1'b0;
    exp_err = 0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          c = 4'($urandom_range(0, 15));
          b = 8'($urandom);
          send_byte({4'h1, c});
          idle($urandom_range(0, 6));
          send_byte(b);
          exp_addr.push_back(c);
          exp_data.push_back(b);
        end
        1: begin
          b = 8'($urandom_range(8'h20, 8'h27));
          send_byte(b);
          exp_rgb = b[2:0];
        end
        2: begin
          send_byte(8'h40);
          for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 3));
            send_byte(b);
            exp_addr.push_back(4'(k));
            exp_data.push_back(b);
          end
        end
        3: begin
          send_byte(8'h30);
          for (int k = 0; k < 16; k++) begin
            exp_addr.push_back(4'(k));
            exp_data.push_back(8'h00);
          end
          idle(18);
        end
        4: begin
          do b = 8'($urandom); while (is_valid_opcode(b));
          send_byte(b);
          exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        default: begin
          send_byte(8'h50);
          idle($urandom_range(0, 10));
          pulse_boundary();
          exp_front = ~exp_front;
        end
      endcase
      idle($urandom_range(0, 4));
    end
    idle(3);
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("[TB] FAIL rand_write_count got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
    if (obs_addr.size() == exp_addr.size()) begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++; if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin errors++; $display("[TB] FAIL rand_write%0d got %h expected %h", i, {obs_addr[i], obs_data[i]}, {exp_addr[i], exp_data[i]}); end
      end
    end
    checks++; if (rgb !== exp_rgb) begin errors++; $display("[TB] FAIL rand_rgb got %b expected %b", rgb, exp_rgb); end
    checks++; if (front_sel !== exp_front) begin errors++; $display("[TB] FAIL rand_front got %b expected %b", front_sel, exp_front); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL rand_errcnt got %0d expected %0d", err_count, exp_err); end
    checks++; if ({busy, err_overrun} !== 2'b00) begin errors++; $display("[TB] FAIL rand_busy_ovr got %b expected 00", {busy, err_overrun}); end
  endtask

  initial begin
    test_reset();
    test_set_col();
    test_frame();
    test_clear_drop();
    test_swap();
    test_reset_abort();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
